// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk, reset   - clock (rising edge) and asynchronous active-high reset
//   start        - request a division; accepted only when not busy
//   dividend     - WIDTH-bit unsigned operand, captured on an accepted start
//   divisor      - WIDTH-bit unsigned operand, captured on an accepted start
//   busy         - high during the WIDTH iteration cycles
//   done         - one-cycle pulse, quotient/remainder/div_by_zero valid
//   quotient     - result, held until the next completion
//   remainder    - result, held until the next completion
//   div_by_zero  - last accepted operation had divisor == 0
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    // One restoring step. The extra MSB keeps the compare exact when the
    // shifted partial remainder reaches 2^WIDTH; trial[WIDTH] is the borrow.
    partial  = {rem_q, quo_q[WIDTH-1]};
    trial    = partial - {1'b0, divisor_q};
    step_rem = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    state_d     = state_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          divisor_d = divisor;
          rem_d     = '0;
          quo_d     = dividend;
          count_d   = '0;
          dbz_d     = 1'b0;
          if (divisor == '0) begin
            // Zero divisor skips iteration and publishes results directly.
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          quotient_d  = step_quo;
          remainder_d = step_rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  // Result values the outputs are expected to hold between completions.
  logic [W-1:0] exp_q;
  logic [W-1:0] exp_r;
  logic         exp_z;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge. Drives start for one cycle, then walks edge by edge
  // (the sampling edge counts as edge 1) until the expected done cycle.
  // inj_k > 0 re-pulses start with ia/ib after edge inj_k, which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_k, input logic [W-1:0] ia, input logic [W-1:0] ib);
    int           lat;
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    logic         mz;
    if (b == '0) begin
      mq = '1; mr = a; mz = 1'b1; lat = 1;
    end else begin
      mq = a / b; mr = a % b; mz = 1'b0; lat = W + 1;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == inj_k) begin
        start    = 1'b1;
        dividend = ia;
        divisor  = ib;
      end
      if (k < lat) begin
        chk1("busy_calc", busy, 1'b1);
        chk1("done_early", done, 1'b0);
        chk32("quot_hold", quotient, exp_q);
        chk32("rem_hold", remainder, exp_r);
      end else begin
        chk1("busy_at_done", busy, 1'b0);
        chk1("done_pulse", done, 1'b1);
        chk32("quotient", quotient, mq);
        chk32("remainder", remainder, mr);
        chk1("div_by_zero", div_by_zero, mz);
      end
    end
    exp_q = mq;
    exp_r = mr;
    exp_z = mz;
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_done", done, 1'b0);
    chk32("idle_quot", quotient, exp_q);
    chk32("idle_rem", remainder, exp_r);
    chk1("idle_dbz", div_by_zero, exp_z);
  endtask

  task automatic zero_check(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk32({tag, "_quot"}, quotient, '0);
    chk32({tag, "_rem"}, remainder, '0);
    chk1({tag, "_dbz"}, div_by_zero, 1'b0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           sel;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    exp_q    = '0;
    exp_r    = '0;
    exp_z    = 1'b0;

    // Reset state, and start ignored while reset is high.
    repeat (2) @(negedge clk);
    zero_check("rst");
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd3;
    @(negedge clk);
    zero_check("rst_start");
    start = 1'b0;
    reset = 1'b0;
    idle_check();

    // Directed cases.
    run_op(32'd100, 32'd7, 0, '0, '0);
    idle_check();
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 0, '0, '0);
    idle_check();
    run_op(32'hFFFF_FFFF, 32'd1, 0, '0, '0);
    idle_check();
    run_op(32'h1234, 32'd0, 0, '0, '0);
    idle_check();
    run_op(32'd5, 32'd9, 0, '0, '0);
    idle_check();

    // Start during CALC ignored; start during DONE accepted back-to-back.
    run_op(32'd50, 32'd5, 10, 32'd8, 32'd2);
    run_op(32'd8, 32'd2, 0, '0, '0);
    idle_check();

    // Reset in CALC cycle 16 aborts with outputs cleared at once.
    start    = 1'b1;
    dividend = 32'd123456;
    divisor  = 32'd789;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk1("pre_abort_busy", busy, 1'b1);
    #1 reset = 1'b1;
    #1 zero_check("abort");
    exp_q = '0;
    exp_r = '0;
    exp_z = 1'b0;
    repeat (3) begin
      @(negedge clk);
      zero_check("abort_hold");
    end
    reset = 1'b0;
    idle_check();
    run_op(32'd9, 32'd4, 0, '0, '0);
    idle_check();

    // Randomized operations, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom >> $urandom_range(0, 31);
        3:       b = (a == '1) ? $urandom : a + 1;
        default: b = $urandom;
      endcase
      run_op(a, b, 0, '0, '0);
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have input clk, 1 bit: clock, all state updates on rising edge.
REQ-003 The block SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have input start, 1 bit: request a new division, sampled on a rising clk edge.
REQ-005 The block SHALL have input dividend, WIDTH bits, unsigned, captured when start is accepted.
REQ-006 The block SHALL have input divisor, WIDTH bits, unsigned, captured when start is accepted.
REQ-007 The block SHALL have output busy, 1 bit: high while iterating.
REQ-008 The block SHALL have output done, 1 bit: single-cycle pulse marking that the results are valid.
REQ-009 The block SHALL have output quotient, WIDTH bits: the result.
REQ-010 The block SHALL have output remainder, WIDTH bits: the result.
REQ-011 The block SHALL have output div_by_zero, 1 bit: the last accepted operation had divisor == 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 The FSM SHALL accept start only when busy = 0, i.e. in IDLE or DONE. An accepted start SHALL capture dividend and divisor, clear div_by_zero and load the working registers: rem = 0, quo = dividend, count = 0.
REQ-014 start asserted while busy = 1 SHALL be ignored, with no effect on operands, state or outputs.
REQ-015 An accepted start with divisor != 0 SHALL move the FSM to CALC. An accepted start with divisor == 0 SHALL move the FSM directly to DONE.
REQ-016 Each CALC cycle SHALL perform one restoring step:
- shift {rem, quo} left by 1 into a (WIDTH+1)-bit partial remainder;
- compute trial = partial - {1'b0, divisor} at WIDTH+1 bits;
- if trial is non-negative: rem = trial[WIDTH-1:0] and quo[0] = 1;
- otherwise: rem = partial[WIDTH-1:0] and quo[0] = 0.
REQ-017 The trial subtraction SHALL use WIDTH+1 bits so that a partial remainder of 2^WIDTH or more never produces a wrong compare.
REQ-018 count SHALL increment once per CALC cycle. After the WIDTH-th CALC cycle the FSM SHALL go to DONE.
REQ-019 busy SHALL be 1 exactly in CALC, for WIDTH consecutive cycles per non-zero-divisor operation.
REQ-020 On entry to DONE, quotient and remainder SHALL be updated from quo and rem, and done SHALL be 1 for exactly one cycle.
- Non-zero divisor: done is high in the cycle beginning WIDTH+1 rising edges after the edge that sampled start.
- Zero divisor: done is high in the cycle beginning 1 edge after the edge that sampled start.
REQ-021 For divisor == 0, DONE SHALL present quotient = all ones, remainder = dividend and div_by_zero = 1.
REQ-022 DONE SHALL return to IDLE after one cycle, unless start is asserted in DONE; that start SHALL be accepted per REQ-013 and REQ-015, giving back-to-back operation.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values from done until the next DONE entry, and SHALL NOT change during CALC.
REQ-024 For every non-zero divisor the results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor.
REQ-025 If divisor > dividend, the results SHALL be quotient = 0 and remainder = dividend, with the full WIDTH-cycle latency.

Reset
REQ-026 On reset assertion, the block SHALL immediately enter IDLE and set busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, and clear all working registers and count.
REQ-027 Reset asserted in CALC SHALL abort the operation with no done pulse. The first start after reset deassertion SHALL behave as from power-up.
REQ-028 start SHALL be ignored while reset is high.

Verification
REQ-029 Directed scenario, basic division: WIDTH=32, dividend=100, divisor=7, start for 1 cycle -> busy high for 32 cycles; done high 33 edges after the start edge; quotient=14, remainder=2, div_by_zero=0.
REQ-030 Directed scenario, wide compare: dividend=0xFFFFFFFF, divisor=0x80000000 -> quotient=1, remainder=0x7FFFFFFF. Then dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-031 Directed scenario, divide by zero: dividend=0x1234, divisor=0 -> done 1 edge after start; busy never high; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
REQ-032 Directed scenario, divisor larger than dividend: dividend=5, divisor=9 -> quotient=0, remainder=5, done at 33 edges.
REQ-033 Directed scenario, start while busy: start 50/5, then pulse start with 8/2 during CALC cycle 10 -> the second start is ignored; a single done; quotient=10, remainder=0. Then start 8/2 during the DONE cycle -> accepted; quotient=4, remainder=0 after a further 33 edges.
REQ-034 Directed scenario, reset mid-operation: assert reset in CALC cycle 16 -> all outputs 0 immediately; no done pulse. Then start 9/4 -> quotient=2, remainder=1.
